// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        PAR   = 3'd2,
        GAP   = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Power-on pattern used by link-test setups that do not program their own.
    localparam logic [4:0] DEF_PATTERN = 5'b10101;
    localparam int         DEF_LEN     = 5;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/serial-output bundle of seq_pattern_tx, plus FSM/counter observation signals.
interface seq_pattern_tx_if
    import seq_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    // start is a request with no ready: it is taken only while the transmitter is
    // idle (busy=0 and not in the done cycle); err answers a bad length, busy covers
    // the transfer, done closes it. dout is meaningful only while dout_valid=1.
    logic               start;
    logic               abort;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [CNT_W-1:0]   rep;
    logic [CNT_W-1:0]   gap;
    logic               dout;
    logic               dout_valid;
    logic               frame_start;
    logic               busy;
    logic               done;
    logic               err;
    state_t             state;
    logic [CNT_W-1:0]   rep_left;
    logic [CNT_W-1:0]   gap_left;

    modport master (
        output start, abort, pattern, len, rep, gap,
        input  dout, dout_valid, frame_start, busy, done, err, state, rep_left, gap_left
    );

    modport slave (
        input  start, abort, pattern, len, rep, gap,
        output dout, dout_valid, frame_start, busy, done, err, state, rep_left, gap_left
    );
endinterface

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; load takes priority over decrement.
module seq_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: MSB-first frames with repeats and idle gaps.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit to every frame.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input logic             clk,
    input logic             rst,
    seq_pattern_tx_if.slave bus
);

    state_t             state, state_n;
    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic [CNT_W-1:0]   gap_r;
    logic               latch_en;

    logic               dout_q, valid_q, fs_q, busy_q, done_q, err_q;
    logic               dout_n, valid_n, fs_n, busy_n, done_n, err_n;

    logic               bit_load, bit_dec, bit_zero;
    logic [LEN_W-1:0]   bit_val, bit_cnt;
    logic               rep_load, rep_dec, rep_zero;
    logic [CNT_W-1:0]   rep_cnt;
    logic               gap_load, gap_dec, gap_zero;
    logic [CNT_W-1:0]   gap_cnt;
    logic               end_frame, new_frame, len_ok;

    function automatic logic bit_at(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] k);
        bit_at = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) == k) bit_at = p[i];
        end
    endfunction

    assign len_ok = (bus.len != '0) && (bus.len <= LEN_W'(MAX_LEN));

`ifdef SEQ_PATTERN_TX_PARITY_EN
    logic parity;
    always_comb begin
        parity = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len_r) parity = parity ^ pat_r[i];
        end
    end
`endif

    // Outputs are computed for the next cycle and registered, so each state's
    // branch describes what the line shows after the coming edge.
    always_comb begin
        state_n   = state;
        dout_n    = 1'b0;
        valid_n   = 1'b0;
        fs_n      = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        latch_en  = 1'b0;
        bit_load  = 1'b0;
        bit_dec   = 1'b0;
        bit_val   = len_r - LEN_W'(1);
        rep_load  = 1'b0;
        rep_dec   = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        end_frame = 1'b0;
        new_frame = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (len_ok) begin
                        latch_en = 1'b1;
                        rep_load = 1'b1;
                        bit_load = 1'b1;
                        bit_val  = bus.len - LEN_W'(1);
                        state_n  = SHIFT;
                        busy_n   = 1'b1;
                        valid_n  = 1'b1;
                        fs_n     = 1'b1;
                        dout_n   = bit_at(bus.pattern, bus.len - LEN_W'(1));
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (!bit_zero) begin
                    bit_dec = 1'b1;
                    busy_n  = 1'b1;
                    valid_n = 1'b1;
                    dout_n  = bit_at(pat_r, bit_cnt - LEN_W'(1));
                end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    state_n = PAR;
                    busy_n  = 1'b1;
                    valid_n = 1'b1;
                    dout_n  = parity;
`else
                    end_frame = 1'b1;
`endif
                end
            end
`ifdef SEQ_PATTERN_TX_PARITY_EN
            PAR: begin
                if (bus.abort) state_n = IDLE;
                else           end_frame = 1'b1;
            end
`endif
            GAP: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (gap_zero) begin
                    new_frame = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (end_frame) begin
            if (!rep_zero) begin
                rep_dec = 1'b1;
                if (gap_r != '0) begin
                    state_n  = GAP;
                    gap_load = 1'b1;
                    busy_n   = 1'b1;
                end else begin
                    new_frame = 1'b1;
                end
            end else begin
                state_n = FIN;
                done_n  = 1'b1;
            end
        end

        if (new_frame) begin
            state_n  = SHIFT;
            bit_load = 1'b1;
            busy_n   = 1'b1;
            valid_n  = 1'b1;
            fs_n     = 1'b1;
            dout_n   = bit_at(pat_r, len_r - LEN_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pat_r   <= '0;
            len_r   <= '0;
            gap_r   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            dout_q  <= dout_n;
            valid_q <= valid_n;
            fs_q    <= fs_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
            if (latch_en) begin
                pat_r <= bus.pattern;
                len_r <= bus.len;
                gap_r <= bus.gap;
            end
        end
    end

    seq_down_counter #(.W(LEN_W)) u_bit_cnt (
        .clk(clk), .rst(rst), .load(bit_load), .dec(bit_dec),
        .load_val(bit_val), .count(bit_cnt), .zero(bit_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_rep_cnt (
        .clk(clk), .rst(rst), .load(rep_load), .dec(rep_dec),
        .load_val(bus.rep), .count(rep_cnt), .zero(rep_zero)
    );

    // Loaded with gap-1 so the idle stretch ends on the zero flag, giving
    // exactly gap cycles even at the counter's maximum value.
    seq_down_counter #(.W(CNT_W)) u_gap_cnt (
        .clk(clk), .rst(rst), .load(gap_load), .dec(gap_dec),
        .load_val(gap_r - CNT_W'(1)), .count(gap_cnt), .zero(gap_zero)
    );

    assign bus.dout        = dout_q;
    assign bus.dout_valid  = valid_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.state       = state;
    assign bus.rep_left    = rep_cnt;
    assign bus.gap_left    = gap_cnt;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: per-cycle queue model of frames plus literal pins per directed run.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int W       = 6;
  // output word layout: {busy, valid, dout, frame_start, done, err}
  localparam int B_BUSY = 5;
  localparam int B_DONE = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_now;
  logic [W-1:0] act;
  int n_checks = 0;
  int n_pass   = 0;

  // per-transfer log, owned by the compare process
  logic        log_on = 1'b0;
  logic [63:0] log_bits;
  int          log_nbits, log_busy, log_fs, log_lat, log_done;

  // literal expectations for the current directed transfer, written by the driver
  logic        lit_en = 1'b0;
  logic [63:0] lit_bits;
  int          lit_nbits, lit_busy, lit_fs, lit_lat;

  function automatic void chk(input string name, input longint a, input longint e);
    n_checks++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, a, e);
  endfunction

  // Expected output stream of one accepted request, one word per cycle.
  function automatic void build(input logic [MAX_LEN-1:0] p, input int l, input int r, input int g);
    logic par;
    par = 1'b0;
    for (int b = 0; b < l; b++) par = par ^ p[b];
    for (int f = 0; f <= r; f++) begin
      for (int b = l - 1; b >= 0; b--) exp_q.push_back({1'b1, 1'b1, p[b], (b == l - 1), 1'b0, 1'b0});
`ifdef SEQ_PATTERN_TX_PARITY_EN
      exp_q.push_back({1'b1, 1'b1, par, 1'b0, 1'b0, 1'b0});
`endif
      if (f < r) for (int k = 0; k < g; k++) exp_q.push_back(6'b100000);
    end
    exp_q.push_back(6'b000010);
  endfunction

  // ---------------- compare process ----------------
  initial begin
    logic idle;
    int   l;
    exp_now = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_now = '0;
        log_on  = 1'b0;
      end
      act = {bus.busy, bus.dout_valid, bus.dout, bus.frame_start, bus.done, bus.err};
      n_checks++;
      if (act === exp_now) n_pass++;
      else $display("FAIL outputs t=%0t: got busy/valid/dout/fs/done/err=%b, want %b", $time, act, exp_now);
      if (rst) begin
        n_checks++;
        if (bus.state === IDLE) n_pass++;
        else $display("FAIL reset_state: got %0d, want %0d", bus.state, IDLE);
      end

      if (log_on) begin
        log_lat++;
        if (bus.dout_valid) begin
          log_bits = {log_bits[62:0], bus.dout};
          log_nbits++;
        end
        if (bus.busy) log_busy++;
        if (bus.frame_start) log_fs++;
        if (bus.done) log_done++;
        if (exp_now[B_DONE]) begin
          if (lit_en) begin
            chk("lit_nbits", log_nbits, lit_nbits);
            chk("lit_busy", log_busy, lit_busy);
            chk("lit_frame_start", log_fs, lit_fs);
            chk("lit_done_latency", log_lat, lit_lat);
            chk("lit_done_count", log_done, 1);
            if (lit_nbits <= 64) chk("lit_bits", log_bits, lit_bits);
          end
          log_on = 1'b0;
        end
      end

      if (!rst) begin
        idle = (exp_q.size() == 0) && !exp_now[B_BUSY] && !exp_now[B_DONE];
        l    = int'(bus.len);
        if (exp_now[B_BUSY] && bus.abort) begin
          exp_q.delete();
          log_on  = 1'b0;
          exp_now = '0;
        end else if (idle && bus.start && !bus.abort) begin
          if (l >= 1 && l <= MAX_LEN) begin
            build(bus.pattern, l, int'(bus.rep), int'(bus.gap));
            log_on    = 1'b1;
            log_bits  = '0;
            log_nbits = 0;
            log_busy  = 0;
            log_fs    = 0;
            log_lat   = 0;
            log_done  = 0;
            exp_now   = exp_q.pop_front();
          end else begin
            exp_now = 6'b000001;
          end
        end else if (exp_q.size() > 0) begin
          exp_now = exp_q.pop_front();
        end else begin
          exp_now = '0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p, input int l, input int r, input int g);
    bus.start   = 1'b1;
    bus.pattern = p;
    bus.len     = LEN_W'(l);
    bus.rep     = CNT_W'(r);
    bus.gap     = CNT_W'(g);
    tick(1);
    bus.start   = 1'b0;
    bus.pattern = MAX_LEN'($urandom);
    bus.len     = LEN_W'($urandom_range(0, 15));
    bus.rep     = CNT_W'($urandom);
    bus.gap     = CNT_W'($urandom);
  endtask

  task automatic set_lit(input logic en, input logic [63:0] bits, input int nb, input int bz,
                         input int fs, input int lat);
    lit_en    = en;
    lit_bits  = bits;
    lit_nbits = nb;
    lit_busy  = bz;
    lit_fs    = fs;
    lit_lat   = lat;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.rep     = '0;
    bus.gap     = '0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // single 5-bit frame
`ifdef SEQ_PATTERN_TX_PARITY_EN
    set_lit(1'b1, 64'b101011, 6, 6, 1, 7);
`else
    set_lit(1'b1, 64'b10101, 5, 5, 1, 6);
`endif
    send(8'b10101, 5, 0, 0);
    tick(lit_lat + 3);

    // three frames with gaps; a start mid-transfer must be ignored
`ifdef SEQ_PATTERN_TX_PARITY_EN
    set_lit(1'b1, 64'b101011101011101011, 18, 24, 3, 25);
`else
    set_lit(1'b1, 64'b101011010110101, 15, 21, 3, 22);
`endif
    send(8'b10101, 5, 2, 3);
    tick(4);
    bus.start = 1'b1;
    bus.len   = 4'd3;
    tick(1);
    bus.start = 1'b0;
    tick(lit_lat + 2);

    // back-to-back frames
`ifdef SEQ_PATTERN_TX_PARITY_EN
    set_lit(1'b1, 64'b11001100, 8, 8, 2, 9);
`else
    set_lit(1'b1, 64'b110110, 6, 6, 2, 7);
`endif
    send(8'b110, 3, 1, 0);
    tick(lit_lat + 3);

    // rejected lengths, and abort winning over start in idle
    set_lit(1'b0, 64'd0, 0, 0, 0, 0);
    send(8'b10101, 0, 0, 0);
    tick(2);
    send(8'b10101, 9, 0, 0);
    tick(2);
    bus.abort = 1'b1;
    send(8'b10101, 5, 0, 0);
    bus.abort = 1'b0;
    tick(3);

    // abort on the third bit
    send(8'b10101, 5, 0, 0);
    tick(2);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    tick(4);

    // asynchronous reset on the third bit
    send(8'b10101, 5, 0, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(4);

    // single-bit frames: frame_start on every data bit
`ifdef SEQ_PATTERN_TX_PARITY_EN
    set_lit(1'b1, 64'b11111111, 8, 8, 4, 9);
`else
    set_lit(1'b1, 64'b1111, 4, 4, 4, 5);
`endif
    send(8'b1, 1, 3, 0);
    tick(lit_lat + 3);

    // maximum repeat count
`ifdef SEQ_PATTERN_TX_PARITY_EN
    set_lit(1'b1, 64'd0, 512, 512, 256, 513);
`else
    set_lit(1'b1, 64'd0, 256, 256, 256, 257);
`endif
    send(8'b0, 1, 255, 0);
    tick(lit_lat + 3);

    // maximum gap
`ifdef SEQ_PATTERN_TX_PARITY_EN
    set_lit(1'b1, 64'b1111, 4, 259, 2, 260);
`else
    set_lit(1'b1, 64'b11, 2, 257, 2, 258);
`endif
    send(8'b1, 1, 1, 255);
    tick(lit_lat + 3);

    // start held through the last bit and the done cycle
    set_lit(1'b0, 64'd0, 0, 0, 0, 0);
    send(8'b11, 2, 0, 0);
    tick(1);
    bus.start   = 1'b1;
    bus.pattern = 8'b01;
    bus.len     = 4'd2;
    bus.rep     = '0;
    bus.gap     = '0;
    tick(3);
    bus.start = 1'b0;
    tick(6);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.start   = ($urandom_range(0, 9) == 0);
      bus.abort   = ($urandom_range(0, 39) == 0);
      bus.pattern = MAX_LEN'($urandom);
      bus.len     = LEN_W'($urandom_range(0, 9));
      bus.rep     = CNT_W'($urandom_range(0, 3));
      bus.gap     = CNT_W'($urandom_range(0, 3));
      rst         = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: serialises a programmable bit pattern, MSB-first, onto a single-bit line with a valid qualifier.
- Pattern and length are programmable, up to MAX_LEN bits. A frame can repeat a programmable number of times, with idle gap cycles between frames.
- Sits on the driving side of the team's serial sequence-detector path; used as an on-chip stimulus source and a link-test generator.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of len input; must satisfy 2**LEN_W > MAX_LEN.
- CNT_W, 8, width of repeat and gap counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request transmission; sampled only in IDLE
- abort  in  1  synchronous cancel of an active transmission
- pattern  in  MAX_LEN  bits to send; bit [len-1] goes out first, bit [0] last
- len  in  LEN_W  number of pattern bits per frame, valid range 1..MAX_LEN
- rep  in  CNT_W  extra repetitions; total frames = rep+1
- gap  in  CNT_W  idle cycles between consecutive frames
- dout  out  1  serial data
- dout_valid  out  1  dout carries a pattern (or parity) bit this cycle
- frame_start  out  1  one-cycle pulse coincident with the first bit of each frame
- busy  out  1  transmission in progress
- done  out  1  one-cycle pulse after the last bit of the last frame
- err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- All outputs are registered. Reset value of every output is 0; the FSM resets to IDLE.
- States:
  - IDLE
  - SHIFT: emitting data bits
  - PAR: parity bit, present only with the optional feature
  - GAP: inter-frame idle
  - FIN: done pulse
- IDLE, start=1, len in 1..MAX_LEN:
  - Latch pattern, len, rep and gap into internal registers; later input changes are ignored.
  - Go to SHIFT.
  - Next cycle: busy=1, dout_valid=1, frame_start=1, dout=pattern[len-1].
- IDLE, start=1, len=0 or len>MAX_LEN: err=1 next cycle, remain IDLE, busy stays 0.
- SHIFT:
  - Bit index counts len-1 down to 0, one bit per cycle.
  - After bit 0, the next state is chosen in this order:
    - PAR, if the parity feature is enabled;
    - else GAP, if frames remain and gap>0;
    - else SHIFT for a new frame, if frames remain and gap=0 (back-to-back, no bubble);
    - else FIN.
- GAP: dout=0, dout_valid=0, busy=1 for exactly gap cycles, then SHIFT of the next frame.
- FIN: done=1, busy=0, dout_valid=0 for one cycle, then IDLE.
  - A start in the FIN cycle is ignored; the earliest accepted start is in the following IDLE cycle.
- Latency and totals:
  - start accepted at cycle N → first bit at N+1.
  - Total busy cycles = (rep+1)*len + rep*gap, plus (rep+1) with parity.
  - done is asserted at the cycle after the final bit.
- dout=0 whenever dout_valid=0.
- start while busy: ignored; no err pulse.
- abort while busy: next cycle go to IDLE with all outputs 0; no done pulse.
- abort in IDLE: no effect. abort and start in the same IDLE cycle: abort wins, nothing is launched.
- Counters do not wrap:
  - rep=2**CNT_W-1 yields exactly 2**CNT_W frames.
  - gap=2**CNT_W-1 yields exactly that many idle cycles.
- len=1: every frame is a single bit, and frame_start is asserted on every data bit.
- Reset mid-transmission: immediate return to IDLE with outputs 0; no done pulse.

Optional Feature:
- Macro: SEQ_PATTERN_TX_PARITY_EN.
- Defined: after bit 0 of each frame, one PAR cycle with dout_valid=1 and dout equal to the even parity (XOR) of the len transmitted bits. frame_start is not asserted on the parity bit. Busy-length formula includes +1 per frame.
- Undefined: PAR state and parity logic are absent, and frames are exactly len bits.

Decomposition:
- Shared package seq_pkg holds:
  - the FSM state enum (IDLE, SHIFT, PAR, GAP, FIN);
  - the default pattern constant 5'b10101 and the default length 5.
- One sub-module, seq_down_counter (loadable down-counter with zero flag), instantiated three times: bit index, repeat count, gap count.

Test Plan:
- pattern=5'b10101, len=5, rep=0, gap=0 → dout 1,0,1,0,1 with valid for cycles N+1..N+5, frame_start at N+1, done at N+6, busy low at N+6.
- Same pattern, rep=2, gap=3 → three frames, each followed except the last by 3 cycles of dout_valid=0; busy high for 21 cycles; done exactly once.
- rep=1, gap=0, len=3, pattern=3'b110 → 1,1,0,1,1,0 contiguous; frame_start at cycles 1 and 4.
- len=0 start → err pulse next cycle, busy=0. Then len=9 with MAX_LEN=8 → err pulse. start while busy → ignored, sequence unaffected.
- abort on the 3rd bit of a 5-bit frame → next cycle busy=0, dout_valid=0, no done. Repeat the scenario with asynchronous rst instead of abort → same outputs.
- With SEQ_PATTERN_TX_PARITY_EN defined and pattern 10101, len=5 → 1,0,1,0,1 followed by parity bit 1, done at N+7.
